// File: rtl/if_fetch_unit_if.sv
// Instruction-bus interface between the IF fetch engine and the memory side.
// Latency: none (wires only).
// Backpressure: req/addr are held by the master until the slave pulses ack.
//
// Signals:
//   bus_req   master->slave  fetch request
//   bus_addr  master->slave  fetch address
//   bus_ack   slave->master  read complete this cycle (may coincide with req)
//   bus_rdata slave->master  instruction word, valid with bus_ack
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine plus IF/ID register, requester side of the stall/flush protocol.
// Latency: bus_ack in cycle N -> inst_valid_o in cycle N+1; zero-wait bus gives 1 instr/cycle.
// Backpressure: stop[0] holds the PC, stop[1] holds IF/ID; an ack arriving while held parks in a 1-entry skid buffer.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   stop[5:0]                controller stall vector (bit0 hold PC, bit1 hold IF/ID)
//   flush, new_pc            pipeline redirect from the controller
//   branch_flag/target       ID-stage taken branch
//   bus                      instruction-bus master port (if_fetch_unit_if.master)
//   stop_req                 stall request towards the controller while a fetch waits
//   inst_o/inst_pc_o/inst_valid_o  IF/ID register
//   exc_adel_o               (IF_ADDR_ERR_EN only) misaligned-fetch exception with the slot
//
// Build option: define IF_ADDR_ERR_EN to trap misaligned PCs instead of masking the low bits.
module if_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stop,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    new_pc,
  input  logic                 branch_flag,
  input  logic [ADDR_W-1:0]    branch_target,
  if_fetch_unit_if.master      bus,
  output logic                 stop_req,
  output logic [31:0]          inst_o,
  output logic [ADDR_W-1:0]    inst_pc_o,
`ifdef IF_ADDR_ERR_EN
  output logic                 exc_adel_o,
`endif
  output logic                 inst_valid_o
);

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Keeps bus_req low until the first edge after reset release.
  logic                r_run;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_stale_addr;

  logic                r_buf_v;
  logic [31:0]         r_buf_inst;
  logic [ADDR_W-1:0]   r_buf_pc;

  logic                r_inst_v;
  logic [31:0]         r_inst;
  logic [ADDR_W-1:0]   r_inst_pc;

  logic                w_bus_req;
  logic [ADDR_W-1:0]   w_bus_addr;
  logic                w_misal;
  logic                w_fetch_done;
  logic                w_slot_err;
  logic                w_new;
  logic                w_avail;
  logic [31:0]         w_new_inst;

  // Only stop[1:0] concern the IF stage.
  logic                w_unused_stop;
  assign w_unused_stop = &{1'b0, stop[5:2]};

`ifdef IF_ADDR_ERR_EN
  logic                r_buf_exc;
  logic                r_exc;
  assign w_misal = (r_pc[1:0] != 2'b00);
`else
  assign w_misal = 1'b0;
`endif

  // Next state and bus drive. In FETCH the request follows the PC, which cannot
  // move before ack or flush, so req/addr stay stable while waiting. A flush of
  // an outstanding request parks in DISCARD replaying the old address until ack.
  always_comb begin
    w_state_nxt = r_state;
    w_bus_req   = 1'b0;
    w_bus_addr  = r_pc;
    case (r_state)
      S_FETCH: begin
        w_bus_req  = r_run & ~r_buf_v & ~w_misal;
        w_bus_addr = r_pc;
        if (flush && w_bus_req && !bus.bus_ack) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        w_bus_req  = 1'b1;
        w_bus_addr = r_stale_addr;
        if (bus.bus_ack) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
`ifndef IF_ADDR_ERR_EN
    w_bus_addr[1:0] = 2'b00;
`endif
  end

  assign bus.bus_req  = w_bus_req;
  assign bus.bus_addr = w_bus_addr;

  assign stop_req = (w_bus_req & ~bus.bus_ack) | (r_state == S_DISCARD);

  // A new IF slot is either a real fetch completing in FETCH or, with the
  // address-error option, a misaligned PC that is issued without a bus cycle.
  assign w_fetch_done = (r_state == S_FETCH) & w_bus_req & bus.bus_ack;
  assign w_slot_err   = r_run & (r_state == S_FETCH) & ~r_buf_v & w_misal;
  assign w_new        = w_fetch_done | w_slot_err;
  assign w_avail      = w_new | r_buf_v;
  assign w_new_inst   = w_slot_err ? 32'h0 : bus.bus_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run        <= 1'b0;
      r_pc         <= RESET_PC;
      r_stale_addr <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_state == S_FETCH && w_state_nxt == S_DISCARD) begin
        r_stale_addr <= w_bus_addr;
      end
      if (flush) begin
        r_pc <= new_pc;
      end else if (!stop[0] && w_avail) begin
        r_pc <= branch_flag ? branch_target : r_pc + ADDR_W'(4);
      end
    end
  end

  // IF/ID register and skid buffer. The buffer only fills while IF/ID is held
  // and drains ahead of any new fetch (bus_req is suppressed while it is full).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_v   <= 1'b0;
      r_inst     <= 32'h0;
      r_inst_pc  <= '0;
      r_buf_v    <= 1'b0;
      r_buf_inst <= 32'h0;
      r_buf_pc   <= '0;
`ifdef IF_ADDR_ERR_EN
      r_buf_exc  <= 1'b0;
      r_exc      <= 1'b0;
`endif
    end else if (flush) begin
      r_inst_v <= 1'b0;
      r_inst   <= 32'h0;
      r_buf_v  <= 1'b0;
`ifdef IF_ADDR_ERR_EN
      r_exc    <= 1'b0;
`endif
    end else if (stop[1]) begin
      if (w_new) begin
        r_buf_v    <= 1'b1;
        r_buf_inst <= w_new_inst;
        r_buf_pc   <= r_pc;
`ifdef IF_ADDR_ERR_EN
        r_buf_exc  <= w_slot_err;
`endif
      end
    end else if (w_avail) begin
      r_inst_v <= 1'b1;
      if (r_buf_v) begin
        r_buf_v   <= 1'b0;
        r_inst    <= r_buf_inst;
        r_inst_pc <= r_buf_pc;
`ifdef IF_ADDR_ERR_EN
        r_exc     <= r_buf_exc;
`endif
      end else begin
        r_inst    <= w_new_inst;
        r_inst_pc <= r_pc;
`ifdef IF_ADDR_ERR_EN
        r_exc     <= w_slot_err;
`endif
      end
    end else begin
      r_inst_v <= 1'b0;
`ifdef IF_ADDR_ERR_EN
      r_exc    <= 1'b0;
`endif
    end
  end

  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign inst_valid_o = r_inst_v;
`ifdef IF_ADDR_ERR_EN
  assign exc_adel_o   = r_exc;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized stalls,
// flushes, branches and bus latencies, checked against a transaction model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stop;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        stop_req;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
`ifdef IF_ADDR_ERR_EN
  logic        exc_adel_o;
`endif

  if_fetch_unit_if #(.ADDR_W(32)) bus ();

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stop          (stop),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .bus           (bus),
    .stop_req      (stop_req),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
`ifdef IF_ADDR_ERR_EN
    .exc_adel_o    (exc_adel_o),
`endif
    .inst_valid_o  (inst_valid_o)
  );

  int checks = 0;
  int errors = 0;

  // Bus slave state
  int          lat_cfg;
  int          lat_left;
  bit          pend;
  logic [31:0] pend_addr;

  // Reference model: architectural PC, skid entry, discard-in-progress and
  // the expected IF/ID contents.
  logic [31:0] pc_m;
  bit          buf_m;
  logic [31:0] buf_i, buf_p;
  bit          buf_e;
  bit          disc_m;
  bit          m_v, m_e;
  logic [31:0] m_i, m_p;
  int          delivered;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    pc_m = 32'h0; buf_m = 0; buf_i = 0; buf_p = 0; buf_e = 0; disc_m = 0;
    m_v = 0; m_e = 0; m_i = 0; m_p = 0; pend = 0; lat_left = 0;
  endtask

  // One clock cycle: entered at posedge+1 with this cycle's controller inputs set.
  task automatic step();
    logic ack, good, slot, avail;
    logic [31:0] w_i;
    bit w_e;
    ack = 1'b0;
    if (pend) chk("req_held", bus.bus_req, 1);
    if (bus.bus_req) begin
      if (pend) chk("addr_stable", bus.bus_addr, pend_addr);
      else begin
        pend = 1; pend_addr = bus.bus_addr;
        lat_left = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        if (!disc_m) chk("fetch_addr", bus.bus_addr, {pc_m[31:2], 2'b00});
      end
      if (lat_left == 0) ack = 1'b1;
      else lat_left--;
    end
    bus.bus_ack   = ack;
    bus.bus_rdata = ack ? mem(bus.bus_addr) : 32'hDEADBEEF;
    #1;
    chk("stop_req", stop_req, (bus.bus_req & ~ack) | disc_m);
    chk("stop_legal", stop[0] & ~stop[1], 0);

    good = ack & ~disc_m;
    slot = 1'b0;
`ifdef IF_ADDR_ERR_EN
    slot = ~disc_m & ~buf_m & (pc_m[1:0] != 2'b00);
`endif
    avail = good | slot | buf_m;
    w_i = slot ? 32'h0 : mem({pc_m[31:2], 2'b00});
    w_e = slot;
    if (flush) begin
      m_v = 0; m_i = 0; m_e = 0; buf_m = 0;
      disc_m = ~ack & (disc_m | bus.bus_req);
      pc_m = new_pc;
    end else begin
      if (stop[1]) begin
        if (good | slot) begin buf_m = 1; buf_i = w_i; buf_p = pc_m; buf_e = w_e; end
      end else if (avail) begin
        m_v = 1;
        if (buf_m) begin m_i = buf_i; m_p = buf_p; m_e = buf_e; buf_m = 0; end
        else begin m_i = w_i; m_p = pc_m; m_e = w_e; end
        delivered++;
      end else begin
        m_v = 0; m_e = 0;
      end
      if (!stop[0] && avail) pc_m = branch_flag ? branch_target : pc_m + 32'd4;
      disc_m = disc_m & ~ack;
    end
    if (ack) pend = 0;

    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    chk("valid", inst_valid_o, m_v);
    chk("inst", inst_o, m_i);
    if (m_v) chk("inst_pc", inst_pc_o, m_p);
`ifdef IF_ADDR_ERR_EN
    chk("exc_adel", exc_adel_o, m_e);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int flush_left;
    int r;
    rst = 1'b0; stop = 6'b0; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    lat_cfg = 0; delivered = 0; flush_left = 0;
    init_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus.bus_req, 0);
    chk("rst_stop_req", stop_req, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_inst_pc", inst_pc_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: zero-wait sequential fetch
    lat_cfg = 0;
    chk("t1_addr0", bus.bus_addr, 32'h0); step();
    chk("t1_addr4", bus.bus_addr, 32'h4); step();
    chk("t1_addr8", bus.bus_addr, 32'h8); step();
    step();

    // 2: 3-cycle wait on 0x10
    lat_cfg = 3;
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr_hold", bus.bus_addr, 32'h10);
      if (i > 0) chk("t2_bubble", inst_valid_o, 0);
      step();
    end

    // 3: ack of 0x14 while stalled lands in the skid buffer
    lat_cfg = 0;
    stop = 6'b000111; step();
    chk("t3_noreq", bus.bus_req, 0); step();
    chk("t3_noreq2", bus.bus_req, 0);
    stop = 6'b0; step();
    chk("t3_buf_pc", inst_pc_o, 32'h14);
    chk("t3_next_addr", bus.bus_addr, 32'h18);

    // 4: 2-cycle flush over an un-acked fetch of 0x20
    step(); step();
    lat_cfg = 6;
    flush = 1'b1; new_pc = 32'h40; step(); step();
    flush = 1'b0;
    for (int i = 0; i < 10 && disc_m; i++) begin
      chk("t4_disc_addr", bus.bus_addr, 32'h20);
      chk("t4_bubble", inst_valid_o, 0);
      step();
    end
    lat_cfg = 0;
    chk("t4_redirect", bus.bus_addr, 32'h40);

    // 5: branch redirect and PC wrap
    flush = 1'b1; new_pc = 32'h8; step(); flush = 1'b0;
    chk("t5_addr8", bus.bus_addr, 32'h8);
    branch_flag = 1'b1; branch_target = 32'h100; step(); branch_flag = 1'b0;
    chk("t5_addr100", bus.bus_addr, 32'h100); step();
    flush = 1'b1; new_pc = 32'hFFFFFFFC; step(); flush = 1'b0;
    chk("t5_addr_top", bus.bus_addr, 32'hFFFFFFFC); step();
    chk("t5_wrap", bus.bus_addr, 32'h0); step();

`ifdef IF_ADDR_ERR_EN
    // 6: misaligned PC raises an address-error slot without a bus cycle
    flush = 1'b1; new_pc = 32'h42; step(); flush = 1'b0;
    chk("t6_noreq", bus.bus_req, 0); step();
    chk("t6_exc", exc_adel_o, 1);
    chk("t6_pc", inst_pc_o, 32'h42);
    chk("t6_noreq2", bus.bus_req, 0); step();
    chk("t6_exc2", exc_adel_o, 1);
    chk("t6_pc2", inst_pc_o, 32'h46);
    flush = 1'b1; new_pc = 32'h80; step(); flush = 1'b0;
`endif

    // Randomized traffic
    lat_cfg = -1;
    delivered = 0;
    for (int n = 0; n < 800; n++) begin
      if (flush_left > 0) begin
        flush = 1'b1; flush_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1; new_pc = 32'($urandom_range(0, 1023)) << 2;
        flush_left = int'($urandom_range(0, 1));
      end else begin
        flush = 1'b0;
      end
      r = int'($urandom_range(0, 9));
      stop = (r == 7) ? 6'b000011 : (r == 8) ? 6'b000111 : (r == 9) ? 6'b001111 : 6'b0;
      if (stop == 6'b0) begin
        branch_flag   = ($urandom_range(0, 9) == 0);
        branch_target = 32'($urandom_range(0, 1023)) << 2;
      end
      step();
    end
    flush = 1'b0; stop = 6'b0; branch_flag = 1'b0;
    chk("liveness", delivered > 100, 1);

    // Reset in the middle of a pending fetch
    lat_cfg = 5;
    step(); step();
    rst = 1'b0; #1;
    chk("rst2_bus_req", bus.bus_req, 0);
    chk("rst2_stop_req", stop_req, 0);
    chk("rst2_valid", inst_valid_o, 0);
    init_model();
    lat_cfg = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_refetch", bus.bus_addr, 32'h0);
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
